// File: rtl/maze_scanner.sv
// Raster-order reader of the maze cell memory; streams (x, y, cell) over valid/ready and counts PATH cells.
// Optional build macro MAZE_SCANNER_SKIP_OUT_EN: OUT cells are read but not presented.
module maze_scanner #(
   parameter int unsigned MAZE_W = 128,
   parameter int unsigned MAZE_H = 64,
   parameter int unsigned X_W    = $clog2(MAZE_W),
   parameter int unsigned Y_W    = $clog2(MAZE_H)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   output logic               rd_en,
   output logic [X_W+Y_W-1:0] rd_addr,
   input  logic [1:0]         rd_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [X_W-1:0]     out_x,
   output logic [Y_W-1:0]     out_y,
   output logic [1:0]         out_cell,
   output logic [X_W+Y_W:0]   path_count,
   output logic               busy,
   output logic               finish
);

   localparam int unsigned A_W = X_W + Y_W;
   localparam int unsigned C_W = A_W + 1;
   localparam logic [1:0] CELL_PATH = 2'b01;
`ifdef MAZE_SCANNER_SKIP_OUT_EN
   localparam logic [1:0] CELL_OUT  = 2'b00;
`endif

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_WAIT,
      ST_PRESENT,
      ST_DONE
   } state_t;

   state_t         state;
   state_t         state_nxt;
   logic [A_W-1:0] addr;
   logic           last;
   logic           clr;
   logic           adv;
   logic           cap;
   logic           inc;

   // {y, x} kept as one counter so the x wrap carries into y for free
   assign last    = (addr == A_W'(MAZE_W * MAZE_H - 1));
   assign rd_addr = addr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // next-state and state-decoded controls
   always_comb begin
      state_nxt = state;
      clr       = 1'b0;
      adv       = 1'b0;
      cap       = 1'b0;
      inc       = 1'b0;
      rd_en     = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      finish    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               clr       = 1'b1;
               state_nxt = ST_READ;
            end
         end
         ST_READ: begin
            busy      = 1'b1;
            rd_en     = 1'b1;
            state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            busy = 1'b1;
            inc  = (rd_data == CELL_PATH);
`ifdef MAZE_SCANNER_SKIP_OUT_EN
            if (rd_data == CELL_OUT) begin
               if (last) begin
                  state_nxt = ST_DONE;
               end else begin
                  adv       = 1'b1;
                  state_nxt = ST_READ;
               end
            end else begin
               cap       = 1'b1;
               state_nxt = ST_PRESENT;
            end
`else
            cap       = 1'b1;
            state_nxt = ST_PRESENT;
`endif
         end
         ST_PRESENT: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) begin
               if (last) begin
                  state_nxt = ST_DONE;
               end else begin
                  adv       = 1'b1;
                  state_nxt = ST_READ;
               end
            end
         end
         ST_DONE: begin
            finish = 1'b1;
            if (start) begin
               clr       = 1'b1;
               state_nxt = ST_READ;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // address counter, PATH counter and presented-cell registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr       <= '0;
         path_count <= '0;
         out_x      <= '0;
         out_y      <= '0;
         out_cell   <= '0;
      end else begin
         if (clr) begin
            addr       <= '0;
            path_count <= '0;
         end else begin
            if (adv) addr <= addr + A_W'(1);
            if (inc) path_count <= path_count + C_W'(1);
         end
         if (cap) begin
            out_x    <= addr[X_W-1:0];
            out_y    <= addr[A_W-1:X_W];
            out_cell <= rd_data;
         end
      end
   end

endmodule

// File: tb/tb_maze_scanner.sv
// Self-checking bench for maze_scanner on a 4x2 maze with a 1-cycle synchronous RAM model.
module tb_maze_scanner;

   localparam int unsigned W  = 4;
   localparam int unsigned H  = 2;
   localparam int unsigned XW = 2;
   localparam int unsigned YW = 1;
   localparam int unsigned AW = 3;
   localparam int          N  = 8;
`ifdef MAZE_SCANNER_SKIP_OUT_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [1:0]    rd_data = 2'b00;
   logic          out_valid;
   logic          out_ready;
   logic [XW-1:0] out_x;
   logic [YW-1:0] out_y;
   logic [1:0]    out_cell;
   logic [AW:0]   path_count;
   logic          busy;
   logic          finish;

   logic [1:0]    mem [N];
   int            errors = 0;
   int            checks = 0;
   int            ex[$], ey[$], ec[$], epc[$];
   int            exp_path;
   int            exp_lat;
   bit            aborted;

   maze_scanner #(.MAZE_W(W), .MAZE_H(H), .X_W(XW), .Y_W(YW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_x(out_x), .out_y(out_y), .out_cell(out_cell), .path_count(path_count),
      .busy(busy), .finish(finish)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_zero(input string pfx);
      check({pfx, "_rd_en"}, 32'(rd_en), 0);
      check({pfx, "_rd_addr"}, 32'(rd_addr), 0);
      check({pfx, "_out_valid"}, 32'(out_valid), 0);
      check({pfx, "_out_x"}, 32'(out_x), 0);
      check({pfx, "_out_y"}, 32'(out_y), 0);
      check({pfx, "_out_cell"}, 32'(out_cell), 0);
      check({pfx, "_path_count"}, 32'(path_count), 0);
      check({pfx, "_busy"}, 32'(busy), 0);
      check({pfx, "_finish"}, 32'(finish), 0);
   endtask

   // Expected stream straight from the raster rules: 3 cycles per presented cell, 2 per skipped one
   task automatic build_model(input int stall_idx, input int stall_len);
      int pc, lat, c;
      ex.delete(); ey.delete(); ec.delete(); epc.delete();
      pc  = 0;
      lat = 0;
      for (int a = 0; a < N; a++) begin
         c = int'(mem[a]);
         if (c == 1) pc++;
         if (SKIP && c == 0) begin
            lat += 2;
         end else begin
            ex.push_back(a % W);
            ey.push_back(a / W);
            ec.push_back(c);
            epc.push_back(pc);
            lat += 3;
         end
      end
      exp_path = pc;
      exp_lat  = lat + ((stall_idx >= 0 && stall_idx < ex.size()) ? stall_len : 0);
   endtask

   // Called at a negedge with the DUT in IDLE or DONE
   task automatic run_scan(input int stall_idx, input int stall_len, input int glitch_cyc,
                           input int abort_idx, output bit ab);
      int idx, cyc, stalled, reads;
      idx = 0; cyc = 0; stalled = 0; reads = 0; ab = 1'b0;
      build_model(stall_idx, stall_len);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check("start_busy", 32'(busy), 1);
      check("start_rd_en", 32'(rd_en), 1);
      check("start_finish", 32'(finish), 0);
      check("start_path_count", 32'(path_count), 0);
      while (!finish && cyc < 300) begin
         if (rd_en) begin
            check("rd_addr", 32'(rd_addr), 32'(reads));
            reads++;
         end
         out_ready = 1'b1;
         if (out_valid) begin
            if (idx == abort_idx) begin
               ab = 1'b1;
               return;
            end
            if (idx >= ex.size()) begin
               check("extra_cell", 32'(idx), 32'(ex.size()));
               break;
            end
            check("out_x", 32'(out_x), 32'(ex[idx]));
            check("out_y", 32'(out_y), 32'(ey[idx]));
            check("out_cell", 32'(out_cell), 32'(ec[idx]));
            check("pc_at_cell", 32'(path_count), 32'(epc[idx]));
            if (idx == stall_idx && stalled < stall_len) begin
               out_ready = 1'b0;
               stalled++;
            end else begin
               idx++;
            end
         end
         start = (cyc == glitch_cyc);
         @(posedge clk);
         @(negedge clk);
         cyc++;
      end
      start     = 1'b0;
      out_ready = 1'b1;
      check("finish_latency", 32'(cyc), 32'(exp_lat));
      check("cells_presented", 32'(idx), 32'(ex.size()));
      check("reads_issued", 32'(reads), 32'(N));
      check("path_count", 32'(path_count), 32'(exp_path));
      for (int k = 0; k < 3; k++) begin
         check("done_finish", 32'(finish), 1);
         check("done_valid", 32'(out_valid), 0);
         check("done_busy", 32'(busy), 0);
         check("done_pc_held", 32'(path_count), 32'(exp_path));
         @(negedge clk);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      out_ready = 1'b1;
      mem       = '{2'b01, 2'b11, 2'b01, 2'b00, 2'b10, 2'b01, 2'b11, 2'b01};
      #1;
      check_zero("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_busy", 32'(busy), 0);
      check("idle_rd_en", 32'(rd_en), 0);

      // full scan, then restart from DONE with a start pulse mid-scan that must be ignored
      run_scan(-1, 0, -1, -1, aborted);
      run_scan(-1, 0, 7, -1, aborted);
      // backpressure on the third presented cell
      run_scan(2, 5, -1, -1, aborted);

      // reset while presenting cell 5
      run_scan(-1, 0, -1, 5, aborted);
      check("abort_reached", 32'(aborted), 1);
      rst_n = 1'b0;
      #1;
      check_zero("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("post_reset_busy", 32'(busy), 0);
         check("post_reset_rd_en", 32'(rd_en), 0);
         check("post_reset_finish", 32'(finish), 0);
      end

      // randomized memories and stall placements
      for (int r = 0; r < 6; r++) begin
         for (int a = 0; a < N; a++) mem[a] = 2'($urandom_range(0, 3));
         run_scan(int'($urandom_range(0, 6)), int'($urandom_range(0, 4)), -1, -1, aborted);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
